divider_bus_adapter: RTL
========================

Name: divider_bus_adapter

Overview:
Memory-mapped I/O front end that feeds the fixed-point 16.16 Divider from the CPU I/O bus and consumes its result.
- Turns bus writes into the divider's write_a/start pulses.
- Latches quotient and flags on div_done.
- Stalls result reads until the division completes.
- Sits between the I/O address decoder and the Divider instance.

Parameters:
- TIMEOUT, 255: max cycles from div_start to div_done before the adapter aborts the wait.
- TW, 8: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus_start  in  1  one-cycle access request, honoured only in IDLE.
- bus_we  in  1  1 = write, 0 = read; sampled with bus_start.
- bus_addr  in  2  register select: 0 dividend, 1 divisor/go, 2 result, 3 status.
- bus_data  in  32  write data; sampled with bus_start.
- bus_q  out  32  read data; valid only while bus_done = 1.
- bus_done  out  1  one-cycle access acknowledge.
- div_write_a  out  1  one-cycle pulse loading div_a into the divider.
- div_a  out  32  dividend to the divider.
- div_start  out  1  one-cycle pulse starting a division.
- div_b  out  32  divisor; held stable from div_start until div_done.
- div_busy  in  1  divider calculating; used only for status.
- div_done  in  1  divider finished; high for one cycle.
- div_valid, div_dbz, div_ovf  in  1 each  divider result flags.
- div_val  in  32  divider quotient in signed 16.16.

Behaviour:
- Reset (async): all registers and outputs are 0; state IDLE; pend=0; timeout count 0; all flags cleared. Reset mid-division discards the in-flight operation. A div_done arriving after reset release is ignored because pend=0.
- Capture path, independent of FSM state: if pend=1 and div_done=1, then in that cycle:
  - res <= div_val.
  - flags <= {div_ovf, div_dbz, div_valid}.
  - pend <= 0; timeout count cleared.
- Timeout: while pend=1, the counter increments each cycle. On reaching TIMEOUT: pend <= 0, tmo flag <= 1 (sticky), res <= 0, valid <= 0.
- FSM states: IDLE, WAIT, ISSUE, ACK.
  - IDLE: on bus_start, latch we/addr/data.
    - If pend=1 and the access is a write to addr 0/1 or a read of addr 2, go to WAIT.
    - Else any write to addr 0 or 1 goes to ISSUE.
    - All other accesses go to ACK.
    - bus_start outside IDLE is ignored.
  - WAIT: leave the cycle after pend falls (done or timeout), then dispatch exactly as from IDLE.
  - ISSUE: exactly one cycle.
    - addr 0: div_write_a=1, div_a=data, dshadow<=data.
    - addr 1: div_start=1, div_b<=data (held), pend<=1, valid<=0, clear dbz/ovf.
    - Then go to ACK.
  - ACK: bus_done=1 for one cycle, then IDLE.
- Read data (bus_q, driven only in ACK, 0 otherwise):
  - addr 0: dshadow.
  - addr 1: div_b.
  - addr 2: res.
  - addr 3: {27'b0, tmo, ovf, dbz, valid, pend}.
- Writes to addr 2 are ignored but acked. Any write to addr 3 clears tmo.
- Latency with bus_start at cycle T and no pending op:
  - Read: bus_done at T+1.
  - Write to addr 0/1: pulse at T+1, bus_done at T+2.
- Latency when stalled: dispatch begins the cycle after the capture, so read done = div_done cycle + 2.
- Simultaneous events:
  - div_done in the same cycle as bus_start: the capture happens first, so the request is not stalled (pend is evaluated as already cleared).
  - Status read while pend=1: never stalls; returns pend=1.
- Arithmetic: none. Fixed-point semantics live entirely in the Divider; the adapter passes 32-bit values unmodified.

Decomposition:
- Shared I/O package holds:
  - register offsets REG_DIVIDEND=0, REG_DIVISOR=1, REG_RESULT=2, REG_STATUS=3;
  - status bit indices;
  - FSM state encoding.
- Natural sub-module: div_timeout_counter (pend-gated counter with clear and expiry flag).
- The Divider itself is instantiated by the parent, not inside this block.

Test Plan:
1. Write addr0=17<<16, write addr1=3<<16, read addr2 with real Divider -> read stalls, then bus_q=0x0005AAAA; status=0x02 (valid=1).
2. Write addr0=1<<16, addr1=0, read addr3 after completion -> dbz=1, valid per divider; result read does not hang.
3. Read addr3 immediately after writing addr1 -> bus_done at T+1, bus_q bit0=1. Read addr2 -> bus_done exactly 2 cycles after the div_done pulse.
4. Stub divider that never asserts div_done, TIMEOUT=16 -> the stalled read completes 17–18 cycles after div_start with bus_q=0 and status bit4=1; writing addr3 clears bit4.
5. Assert rst while in WAIT -> all outputs 0 immediately; a later stale div_done changes nothing; the next read of addr2 returns 0 at T+1.
6. bus_start coincident with div_done while pend=1, reading addr2 -> no stall; bus_done at T+1 with the new quotient.

Source files
------------

// File: rtl/divider_bus_adapter_pkg.sv
// divider_bus_adapter_pkg: register map, status bit positions and FSM encoding for the divider bus adapter
package divider_bus_adapter_pkg;
  localparam logic [1:0] REG_DIVIDEND = 2'd0;
  localparam logic [1:0] REG_DIVISOR  = 2'd1;
  localparam logic [1:0] REG_RESULT   = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;
  localparam int ST_PEND  = 0;
  localparam int ST_VALID = 1;
  localparam int ST_DBZ   = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_TMO   = 4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_ACK} state_e;
endpackage

// File: rtl/divider_bus_adapter_timeout.sv
// div_timeout_counter: counts cycles while en is high and flags expiry after TIMEOUT cycles
// Ports: clk, rst (async, active high), en (count enable, pend), clr (abort count), expired (one-cycle expiry)
module div_timeout_counter #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);
  logic [TW-1:0] cnt_q, cnt_d;
  assign expired = en && !clr && cnt_q == TW'(TIMEOUT - 1);
  always_comb cnt_d = (!en || clr || expired) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/divider_bus_adapter.sv
// divider_bus_adapter: CPU I/O bus front end for the 16.16 divider (operand load, start, result capture, stalled reads)
// Ports: bus_start/bus_we/bus_addr/bus_data request, bus_q/bus_done response;
//        div_write_a/div_a and div_start/div_b drive the divider; div_busy/div_done/div_valid/div_dbz/div_ovf/div_val return from it
module divider_bus_adapter
  import divider_bus_adapter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_start,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_data,
  output logic [31:0] bus_q,
  output logic        bus_done,
  output logic        div_write_a,
  output logic [31:0] div_a,
  output logic        div_start,
  output logic [31:0] div_b,
  input  logic        div_busy,
  input  logic        div_done,
  input  logic        div_valid,
  input  logic        div_dbz,
  input  logic        div_ovf,
  input  logic [31:0] div_val
);
  state_e      state_q, state_d;
  logic        we_q, we_d, pend_q, pend_d, valid_q, valid_d, dbz_q, dbz_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d, res_q, res_d, dshadow_q, dshadow_d, div_b_q, div_b_d, status;
  logic        capture, expired, pend_now, unused_busy;
  assign unused_busy = div_busy;
  assign capture = pend_q && div_done;
  // a done or timeout landing this cycle already counts as not pending for a new request
  assign pend_now = pend_q && !capture && !expired;
  div_timeout_counter #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timeout (
    .clk(clk), .rst(rst), .en(pend_q), .clr(capture), .expired(expired)
  );
  function automatic state_e dispatch(input logic we, input logic [1:0] addr, input logic pend);
    logic stall;
    stall = pend && (we ? addr <= REG_DIVISOR : addr == REG_RESULT);
    return stall ? S_WAIT : (we && addr <= REG_DIVISOR) ? S_ISSUE : S_ACK;
  endfunction
  always_comb begin
    status = '0;
    status[ST_PEND]  = pend_q;
    status[ST_VALID] = valid_q;
    status[ST_DBZ]   = dbz_q;
    status[ST_OVF]   = ovf_q;
    status[ST_TMO]   = tmo_q;
  end
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    addr_d = addr_q;
    data_d = data_q;
    pend_d = pend_q;
    res_d = res_q;
    valid_d = valid_q;
    dbz_d = dbz_q;
    ovf_d = ovf_q;
    tmo_d = tmo_q;
    dshadow_d = dshadow_q;
    div_b_d = div_b_q;
    div_write_a = 1'b0;
    div_start = 1'b0;
    bus_done = 1'b0;
    bus_q = '0;
    if (capture) begin
      res_d = div_val;
      {ovf_d, dbz_d, valid_d} = {div_ovf, div_dbz, div_valid};
      pend_d = 1'b0;
    end else if (expired) begin
      pend_d = 1'b0;
      tmo_d = 1'b1;
      res_d = '0;
      valid_d = 1'b0;
    end
    case (state_q)
      S_IDLE: if (bus_start) begin
        we_d = bus_we;
        addr_d = bus_addr;
        data_d = bus_data;
        state_d = dispatch(bus_we, bus_addr, pend_now);
      end
      // leave only once pend is visibly low, so a stalled read acks two cycles after div_done
      S_WAIT: if (!pend_q) state_d = dispatch(we_q, addr_q, 1'b0);
      S_ISSUE: begin
        state_d = S_ACK;
        if (addr_q == REG_DIVIDEND) begin
          div_write_a = 1'b1;
          dshadow_d = data_q;
        end else begin
          div_start = 1'b1;
          div_b_d = data_q;
          pend_d = 1'b1;
          valid_d = 1'b0;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        bus_done = 1'b1;
        bus_q = addr_q == REG_DIVIDEND ? dshadow_q : addr_q == REG_DIVISOR ? div_b_q : addr_q == REG_RESULT ? res_q : status;
        if (we_q && addr_q == REG_STATUS && !expired) tmo_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign div_a = div_write_a ? data_q : '0;
  // the divisor must already be valid in the div_start cycle, before div_b_q updates
  assign div_b = div_start ? data_q : div_b_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      pend_q <= 1'b0;
      res_q <= '0;
      valid_q <= 1'b0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
      dshadow_q <= '0;
      div_b_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      pend_q <= pend_d;
      res_q <= res_d;
      valid_q <= valid_d;
      dbz_q <= dbz_d;
      ovf_q <= ovf_d;
      tmo_q <= tmo_d;
      dshadow_q <= dshadow_d;
      div_b_q <= div_b_d;
    end
  end
endmodule
